uart_ctrl: RTL and testbench

- 8N1 UART transceiver sitting directly downstream of the core's memory-mapped peripheral port.
- Consumes the TX byte and TX enable that the data-memory/peripheral block produces, and returns TX status to it.
- Deserializes the external RX line and presents the received byte plus an "effective" flag that the core reads and acknowledges.
- Uses a single clock domain; the external RX line is the only asynchronous input.

---
 rtl/uart_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_uart_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl.sv
// ============================================================================
// uart_ctrl : 8N1 UART transceiver for the core's memory-mapped peripheral port
// Revision  : 1.0
// ============================================================================
`default_nettype none

module uart_ctrl #(
  parameter int TICK_DIV = 325
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       uart_tx,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx_status,
  output logic [7:0] rx_data,
  output logic       rx_eff,
  input  logic       rx_read,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int BIT_CYC = 16 * TICK_DIV;
  localparam int BW      = $clog2(BIT_CYC);
  localparam int DW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYC - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  // ---------------------------------------------------------------- transmit
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  tx_state_e     tx_state_q, tx_state_d;
  logic [BW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;
  logic          tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BIT_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_en) begin
          tx_shift_d = tx_data;
          tx_idx_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_cnt_d = '0;
        tx_idx_d = tx_idx_q + 1'b1;
        if (tx_idx_q == 3'd7) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Line level is decoded from next state so the pin comes straight off a flop.
    case (tx_state_d)
      TX_START: tx_line_d = 1'b0;
      TX_DATA:  tx_line_d = tx_shift_d[tx_idx_d];
      default:  tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign uart_tx   = tx_line_q;
  assign tx_status = (tx_state_q == TX_IDLE);

  // ----------------------------------------------------------------- receive
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e     rx_state_q, rx_state_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DW-1:0] rx_div_q, rx_div_d;
  logic [3:0]    rx_tick_q, rx_tick_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_eff_q, rx_eff_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rx_ovr_q, rx_ovr_d;
  logic          rx_tick, rx_mid, rx_samp, rx_fall;

  assign rx_tick = (rx_div_q == DIV_LAST);
  assign rx_mid  = rx_tick && (rx_tick_q == 4'd7);
  assign rx_samp = rx_tick && (rx_tick_q == 4'd15);
  assign rx_fall = rx_prev_q && !rx_sync_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_tick ? '0 : rx_div_q + 1'b1;
    rx_tick_d  = rx_tick ? rx_tick_q + 1'b1 : rx_tick_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_eff_d   = rx_eff_q && !rx_read;
    rx_ferr_d  = 1'b0;
    rx_ovr_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_fall) begin
        rx_div_d   = '0;
        rx_tick_d  = '0;
        rx_state_d = RX_START;
      end
      RX_START: if (rx_mid) begin
        if (rx_sync_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_tick_d  = '0;
          rx_idx_d   = '0;
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: if (rx_samp) begin
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_idx_d   = rx_idx_q + 1'b1;
        if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_samp) begin
        rx_state_d = RX_IDLE;
        if (rx_sync_q) begin
          // A load beats a concurrent read, and that case is not an overrun.
          rx_data_d = rx_shift_q;
          rx_eff_d  = 1'b1;
          rx_ovr_d  = rx_eff_q && !rx_read;
        end else begin
          rx_ferr_d = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_div_q   <= '0;
      rx_tick_q  <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_eff_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_div_q   <= rx_div_d;
      rx_tick_q  <= rx_tick_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_eff_q   <= rx_eff_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_eff       = rx_eff_q;
  assign rx_frame_err = rx_ferr_q;
  assign rx_overrun   = rx_ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_ctrl.sv
// ============================================================================
// tb_uart_ctrl : scoreboard bench for uart_ctrl at TICK_DIV=4 (64 clk per bit)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_uart_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_drv, loopback, dut_rx;
  logic       uart_tx;
  logic [7:0] tx_data;
  logic       tx_en, tx_status;
  logic [7:0] rx_data;
  logic       rx_eff, rx_read, rx_frame_err, rx_overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic tx_mon_en;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  always #5 clk = ~clk;

  assign dut_rx = loopback ? uart_tx : rx_drv;

  uart_ctrl #(.TICK_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rx      (dut_rx),
    .uart_tx      (uart_tx),
    .tx_data      (tx_data),
    .tx_en        (tx_en),
    .tx_status    (tx_status),
    .rx_data      (rx_data),
    .rx_eff       (rx_eff),
    .rx_read      (rx_read),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_tx_idle(input int maxc);
    int n = 0;
    while (!tx_status && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("tx_idle_wait", tx_status, 1);
  endtask

  // Drives one 64-cycle-per-bit frame; lat = cycles into the stop bit until the result shows.
  task automatic send_rx(input logic [7:0] b, input logic stop, output int lat);
    logic [9:0] fr;
    fr  = {stop, b, 1'b0};
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      rx_drv = fr[i];
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        if (i == 9 && lat < 0 && ((rx_eff && rx_data == b) || rx_frame_err)) lat = c;
      end
    end
    rx_drv = 1'b1;
  endtask

  // Serial decoder for the TX pin, sampling each bit at its middle.
  initial begin : tx_mon
    logic       prev;
    logic [7:0] b;
    logic       stp;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !uart_tx && tx_mon_en) begin
        repeat (32) @(negedge clk);
        check("tx_mid_start", uart_tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (64) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (64) @(negedge clk);
        stp = uart_tx;
        check("tx_stop_bit", stp, 1);
        check("tx_pending", tx_exp.size(), 1);
        if (tx_exp.size() > 0) check("tx_byte", b, tx_exp.pop_front());
        prev = 1'b1;
      end else begin
        prev = uart_tx;
      end
    end
  end

  initial begin : rx_mon
    logic eff_prev;
    eff_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_frame_err) ferr_cnt++;
      if (rx_overrun) ovr_cnt++;
      if ((rx_eff && !eff_prev) || rx_overrun) begin
        check("rx_pending", rx_exp.size(), 1);
        if (rx_exp.size() > 0) check("rx_byte", rx_data, rx_exp.pop_front());
      end
      eff_prev = rx_eff;
    end
  end

  initial begin
    logic [9:0] pat;
    int errs, lows, lat, n;

    reset = 1'b1; tx_en = 1'b0; tx_data = 8'h00; rx_read = 1'b0;
    rx_drv = 1'b1; loopback = 1'b0; tx_mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tx_status", tx_status, 1);
    check("rst_rx_eff", rx_eff, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_frame_err", rx_frame_err, 0);
    check("rst_overrun", rx_overrun, 0);
    reset = 1'b0;
    @(negedge clk);

    // TX 0xA5 with an ignored request mid-frame, then a back-to-back 0x3C
    tx_data = 8'hA5; tx_en = 1'b1; tx_exp.push_back(8'hA5);
    @(negedge clk);
    tx_en = 1'b0;
    errs = 0; lows = 0; pat = {1'b1, 8'hA5, 1'b0};
    for (int c = 0; c < 640; c++) begin
      if (uart_tx !== pat[c/64]) errs++;
      if (!tx_status) lows++;
      if (c == 100) begin tx_data = 8'hFF; tx_en = 1'b1; end
      else tx_en = 1'b0;
      @(negedge clk);
    end
    check("tx_a5_wave_errs", errs, 0);
    check("tx_busy_cycles", lows, 640);
    check("tx_idle_after", tx_status, 1);
    tx_data = 8'h3C; tx_en = 1'b1; tx_exp.push_back(8'h3C);
    @(negedge clk);
    tx_en = 1'b0;
    check("b2b_start_bit", uart_tx, 0);
    check("b2b_status", tx_status, 0);
    wait_tx_idle(700);

    // RX 0x3C then read acknowledge
    repeat (5) @(negedge clk);
    rx_exp.push_back(8'h3C);
    send_rx(8'h3C, 1'b1, lat);
    check("rx3c_latency_ok", (lat >= 0 && lat <= 40), 1);
    check("rx3c_eff", rx_eff, 1);
    check("rx3c_data", rx_data, 8'h3C);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    check("rd_eff_clear", rx_eff, 0);
    check("rd_data_hold", rx_data, 8'h3C);

    // False start: 20 low cycles
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    check("fs_eff", rx_eff, 0);
    check("fs_ferr_cnt", ferr_cnt, 0);
    check("fs_ovr_cnt", ovr_cnt, 0);

    // Frame error: 0x55 with stop bit low
    send_rx(8'h55, 1'b0, lat);
    repeat (10) @(negedge clk);
    check("fe_latency_ok", (lat >= 0 && lat <= 40), 1);
    check("fe_ferr_cnt", ferr_cnt, 1);
    check("fe_eff", rx_eff, 0);
    check("fe_data_hold", rx_data, 8'h3C);

    // Overrun: 0x11 then 0x22 with no read
    repeat (10) @(negedge clk);
    rx_exp.push_back(8'h11);
    send_rx(8'h11, 1'b1, lat);
    rx_exp.push_back(8'h22);
    send_rx(8'h22, 1'b1, lat);
    repeat (5) @(negedge clk);
    check("ov_data", rx_data, 8'h22);
    check("ov_eff", rx_eff, 1);
    check("ov_cnt", ovr_cnt, 1);

    // Reset in the middle of a TX frame
    tx_mon_en = 1'b0;
    tx_data = 8'h00; tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    repeat (199) @(negedge clk);
    check("pre_rst_tx_low", uart_tx, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_uart_tx", uart_tx, 1);
    check("midrst_status", tx_status, 1);
    check("midrst_rx_eff", rx_eff, 0);
    reset = 1'b0;
    @(negedge clk);
    tx_mon_en = 1'b1;

    // Loopback 0x81
    loopback = 1'b1;
    repeat (5) @(negedge clk);
    tx_exp.push_back(8'h81);
    rx_exp.push_back(8'h81);
    tx_data = 8'h81; tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    n = 0;
    while (!rx_eff && n < 800) begin
      @(negedge clk);
      n++;
    end
    check("lb_eff", rx_eff, 1);
    check("lb_data", rx_data, 8'h81);
    wait_tx_idle(200);
    repeat (5) @(negedge clk);

    check("tx_queue_drained", tx_exp.size(), 0);
    check("rx_queue_drained", rx_exp.size(), 0);
    check("final_ferr_cnt", ferr_cnt, 1);
    check("final_ovr_cnt", ovr_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
